// File: rtl/branch_unit.sv
//============================================================================
// Module   : branch_unit
// Purpose  : Program-counter owner and branch resolver for the multi-cycle
//            MIPS core. It sequences instruction fetch through a req/ack
//            handshake, resolves the decoder's 4-bit BRop against the register
//            operands, loads the next PC and issues the $31 link write.
// Ports    : i_BranchUnit_clk / i_BranchUnit_rst  - clock, sync active-high reset
//            o_BranchUnit_fetchReq/fetchAddr       - fetch request and address (= PC)
//            i_BranchUnit_fetchAck                 - fetch accepted
//            i_BranchUnit_brValid, BRop, rsData, rtData, imm16, target26
//                                                  - branch resolution inputs
//            o_BranchUnit_instPc                   - address of instruction in flight
//            o_BranchUnit_linkWe / linkAddr        - $31 link write pulse and value
//            o_BranchUnit_taken / err              - redirect / error pulses
// Config   : define BRANCH_STATS_EN to add the saturating counters
//            o_BranchUnit_brCount and o_BranchUnit_takenCount (width STAT_W).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef BRANCH_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic        i_BranchUnit_clk,
  input  logic        i_BranchUnit_rst,
  output logic        o_BranchUnit_fetchReq,
  output logic [31:0] o_BranchUnit_fetchAddr,
  input  logic        i_BranchUnit_fetchAck,
  input  logic        i_BranchUnit_brValid,
  input  logic [3:0]  i_BranchUnit_BRop,
  input  logic [31:0] i_BranchUnit_rsData,
  input  logic [31:0] i_BranchUnit_rtData,
  input  logic [15:0] i_BranchUnit_imm16,
  input  logic [25:0] i_BranchUnit_target26,
  output logic [31:0] o_BranchUnit_instPc,
  output logic        o_BranchUnit_linkWe,
  output logic [31:0] o_BranchUnit_linkAddr,
  output logic        o_BranchUnit_taken,
  output logic        o_BranchUnit_err
`ifdef BRANCH_STATS_EN
  , output logic [STAT_W-1:0] o_BranchUnit_brCount
  , output logic [STAT_W-1:0] o_BranchUnit_takenCount
`endif
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_stateNxt;
  logic [31:0] r_pc;
  logic [31:0] r_instPc;
  logic [31:0] r_linkAddr;
  logic        r_linkWe;
  logic        r_taken;
  logic        r_err;

  logic        w_accept;
  logic [31:0] w_seq;
  logic [31:0] w_btgt;
  logic [31:0] w_jtgt;
  logic [31:0] w_nextPc;
  logic        w_take;
  logic        w_link;
  logic        w_errNow;
  logic        w_cond;
  logic        w_rsNeg;
  logic        w_rsZero;
  logic        w_eq;

  // State register
  always_ff @(posedge i_BranchUnit_clk) begin
    if (i_BranchUnit_rst) r_state <= S_FETCH;
    else                  r_state <= w_stateNxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_stateNxt            = r_state;
    o_BranchUnit_fetchReq = 1'b0;
    w_accept              = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_BranchUnit_fetchReq = 1'b1;
        if (i_BranchUnit_fetchAck) w_stateNxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_BranchUnit_brValid) begin
          w_accept   = 1'b1;
          w_stateNxt = S_FETCH;
        end
      end
      default: w_stateNxt = S_FETCH;
    endcase
  end

  // Branch resolution
  always_comb begin
    w_seq    = r_instPc + 32'd4;
    w_btgt   = w_seq + {{14{i_BranchUnit_imm16[15]}}, i_BranchUnit_imm16, 2'b00};
    w_jtgt   = {w_seq[31:28], i_BranchUnit_target26, 2'b00};
    w_rsNeg  = i_BranchUnit_rsData[31];
    w_rsZero = (i_BranchUnit_rsData == 32'd0);
    w_eq     = (i_BranchUnit_rsData == i_BranchUnit_rtData);
    w_cond   = 1'b0;
    w_take   = 1'b0;
    w_link   = 1'b0;
    w_errNow = 1'b0;
    w_nextPc = w_seq;
    case (i_BranchUnit_BRop)
      4'd0: begin
        // jr: the target is force-aligned; low bits set only flag an error
        w_take   = 1'b1;
        w_nextPc = {i_BranchUnit_rsData[31:2], 2'b00};
        w_errNow = |i_BranchUnit_rsData[1:0];
      end
      4'd1: begin w_take = 1'b1; w_nextPc = w_jtgt; end
      4'd2: begin w_take = 1'b1; w_nextPc = w_jtgt; w_link = 1'b1; end
      4'd3: begin w_cond = 1'b1; w_link = 1'b1; end
      4'd4: begin w_cond = ~w_rsNeg; w_link = 1'b1; end
      4'd5: w_cond = w_rsNeg;
      4'd6: w_cond = ~w_rsNeg;
      4'd7: begin w_cond = w_rsNeg; w_link = 1'b1; end
      4'd8: w_cond = 1'b1;
      4'd9: w_cond = w_eq;
      4'd10: w_cond = ~w_eq;
      4'd11: w_cond = w_rsNeg | w_rsZero;
      4'd12: w_cond = ~w_rsNeg & ~w_rsZero;
      4'd13: w_cond = 1'b0;
      default: w_errNow = 1'b1;
    endcase
    // Conditional forms share the btgt/seq choice; taken follows the
    // decision, even when btgt happens to equal seq.
    if (w_cond) begin
      w_take   = 1'b1;
      w_nextPc = w_btgt;
    end
  end

  // PC, instruction PC, link and pulse registers
  always_ff @(posedge i_BranchUnit_clk) begin
    if (i_BranchUnit_rst) begin
      r_pc       <= RESET_PC;
      r_instPc   <= RESET_PC;
      r_linkAddr <= 32'd0;
      r_linkWe   <= 1'b0;
      r_taken    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_linkWe <= 1'b0;
      r_taken  <= 1'b0;
      r_err    <= 1'b0;
      if (r_state == S_FETCH && i_BranchUnit_fetchAck) r_instPc <= r_pc;
      if (w_accept) begin
        r_pc    <= w_nextPc;
        r_taken <= w_take;
        r_err   <= w_errNow;
        if (w_link) begin
          r_linkWe   <= 1'b1;
          r_linkAddr <= w_seq;
        end
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] r_brCount;
  logic [STAT_W-1:0] r_takenCount;

  always_ff @(posedge i_BranchUnit_clk) begin
    if (i_BranchUnit_rst) begin
      r_brCount    <= '0;
      r_takenCount <= '0;
    end else if (w_accept) begin
      if (i_BranchUnit_BRop <= 4'd12 && r_brCount != '1)
        r_brCount <= r_brCount + 1'b1;
      if (w_take && r_takenCount != '1)
        r_takenCount <= r_takenCount + 1'b1;
    end
  end

  assign o_BranchUnit_brCount    = r_brCount;
  assign o_BranchUnit_takenCount = r_takenCount;
`endif

  assign o_BranchUnit_fetchAddr = r_pc;
  assign o_BranchUnit_instPc    = r_instPc;
  assign o_BranchUnit_linkWe    = r_linkWe;
  assign o_BranchUnit_linkAddr  = r_linkAddr;
  assign o_BranchUnit_taken     = r_taken;
  assign o_BranchUnit_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
//============================================================================
// Module   : tb_branch_unit
// Purpose  : Directed self-checking bench for branch_unit. Expected branch
//            results are queued when a brValid is driven and compared when
//            the one-cycle result pulses appear.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchAck;
  logic        brValid;
  logic [3:0]  BRop;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] instPc;
  logic        linkWe;
  logic [31:0] linkAddr;
  logic        taken;
  logic        err;
`ifdef BRANCH_STATS_EN
  logic [31:0] brCount;
  logic [31:0] takenCount;
`endif

  always #5 clk = ~clk;

  branch_unit dut (
    .i_BranchUnit_clk      (clk),
    .i_BranchUnit_rst      (rst),
    .o_BranchUnit_fetchReq (fetchReq),
    .o_BranchUnit_fetchAddr(fetchAddr),
    .i_BranchUnit_fetchAck (fetchAck),
    .i_BranchUnit_brValid  (brValid),
    .i_BranchUnit_BRop     (BRop),
    .i_BranchUnit_rsData   (rsData),
    .i_BranchUnit_rtData   (rtData),
    .i_BranchUnit_imm16    (imm16),
    .i_BranchUnit_target26 (target26),
    .o_BranchUnit_instPc   (instPc),
    .o_BranchUnit_linkWe   (linkWe),
    .o_BranchUnit_linkAddr (linkAddr),
    .o_BranchUnit_taken    (taken),
    .o_BranchUnit_err      (err)
`ifdef BRANCH_STATS_EN
    , .o_BranchUnit_brCount   (brCount)
    , .o_BranchUnit_takenCount(takenCount)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic        lw;
    logic [31:0] la;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete a fetch of the expected address, then confirm S_WAIT behaviour.
  task automatic fetch(input logic [31:0] addr);
    chk("fetchReq", {31'd0, fetchReq}, 32'd1);
    chk("fetchAddr", fetchAddr, addr);
    fetchAck = 1'b1;
    tick();
    fetchAck = 1'b0;
    chk("instPc", instPc, addr);
    chk("fetchReq_wait", {31'd0, fetchReq}, 32'd0);
  endtask

  task automatic br(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                    input logic [15:0] imm, input logic [25:0] t26,
                    input logic [31:0] epc, input logic etk, input logic elw,
                    input logic [31:0] ela, input logic eer);
    exp_t e;
    e.pc = epc; e.tk = etk; e.lw = elw; e.la = ela; e.er = eer;
    sb.push_back(e);
    BRop = op; rsData = rs; rtData = rt; imm16 = imm; target26 = t26;
    brValid = 1'b1;
    tick();
    brValid = 1'b0;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sb.pop_front();
      chk($sformatf("op%0d_pc", op), fetchAddr, e.pc);
      chk($sformatf("op%0d_taken", op), {31'd0, taken}, {31'd0, e.tk});
      chk($sformatf("op%0d_linkWe", op), {31'd0, linkWe}, {31'd0, e.lw});
      chk($sformatf("op%0d_linkAddr", op), linkAddr, e.la);
      chk($sformatf("op%0d_err", op), {31'd0, err}, {31'd0, e.er});
    end
    tick();
    chk("pulse_clear", {29'd0, taken, linkWe, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fetchAck = 1'b0; brValid = 1'b0; BRop = 4'd0;
    rsData = '0; rtData = '0; imm16 = '0; target26 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_fetchReq", {31'd0, fetchReq}, 32'd1);
    chk("rst_fetchAddr", fetchAddr, 32'h3000);
    chk("rst_instPc", instPc, 32'h3000);
    chk("rst_linkAddr", linkAddr, 32'd0);
    chk("rst_pulses", {29'd0, taken, linkWe, err}, 32'd0);

    // No ack for 3 cycles; a brValid during S_FETCH must be ignored
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin brValid = 1'b1; BRop = 4'd1; target26 = 26'h3FF_FFFF; end
      tick();
      brValid = 1'b0;
      chk("hold_fetchReq", {31'd0, fetchReq}, 32'd1);
      chk("hold_fetchAddr", fetchAddr, 32'h3000);
      chk("hold_taken", {31'd0, taken}, 32'd0);
    end
    fetch(32'h3000);

    // fetchAck in S_WAIT is ignored
    fetchAck = 1'b1;
    tick();
    fetchAck = 1'b0;
    chk("wait_ack_ignored", {31'd0, fetchReq}, 32'd0);

    // beq taken back to itself, then bne not taken
    br(4'd9, 32'd5, 32'd5, 16'hFFFF, 26'd0, 32'h3000, 1'b1, 1'b0, 32'd0, 1'b0);
    fetch(32'h3000);
    br(4'd10, 32'd5, 32'd5, 16'hFFFF, 26'd0, 32'h3004, 1'b0, 1'b0, 32'd0, 1'b0);
    fetch(32'h3004);
    br(4'd13, 32'd0, 32'd0, 16'h0010, 26'd0, 32'h3008, 1'b0, 1'b0, 32'd0, 1'b0);
    fetch(32'h3008);
    br(4'd13, 32'd0, 32'd0, 16'h0010, 26'd0, 32'h300C, 1'b0, 1'b0, 32'd0, 1'b0);
    fetch(32'h300C);
    br(4'd13, 32'd0, 32'd0, 16'h0010, 26'd0, 32'h3010, 1'b0, 1'b0, 32'd0, 1'b0);
    fetch(32'h3010);

    // bgezal with negative rs: links anyway, not taken
    br(4'd4, 32'hFFFF_FFFF, 32'd0, 16'd4, 26'd0, 32'h3014, 1'b0, 1'b1, 32'h3014, 1'b0);
    fetch(32'h3014);

    // jr to F000_0000, then jal within that region
    br(4'd0, 32'hF000_0000, 32'd0, 16'd0, 26'd0, 32'hF000_0000, 1'b1, 1'b0, 32'h3014, 1'b0);
    fetch(32'hF000_0000);
    br(4'd2, 32'd0, 32'd0, 16'd0, 26'h0000100, 32'hF000_0400, 1'b1, 1'b1, 32'hF000_0004, 1'b0);
    fetch(32'hF000_0400);

    // Misaligned jr, then illegal op
    br(4'd0, 32'h0000_4003, 32'd0, 16'd0, 26'd0, 32'h4000, 1'b1, 1'b0, 32'hF000_0004, 1'b1);
    fetch(32'h4000);
    br(4'd14, 32'd0, 32'd0, 16'h0040, 26'd0, 32'h4004, 1'b0, 1'b0, 32'hF000_0004, 1'b1);
    fetch(32'h4004);

    // Reset in the same cycle as brValid(j): no pulses, state restored
    BRop = 4'd1; target26 = 26'h0000_100; brValid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; brValid = 1'b0;
    chk("rstbr_pulses", {29'd0, taken, linkWe, err}, 32'd0);
    chk("rstbr_fetchAddr", fetchAddr, 32'h3000);
    chk("rstbr_instPc", instPc, 32'h3000);
    chk("rstbr_linkAddr", linkAddr, 32'd0);
    tick();
    chk("rstbr_pulses2", {29'd0, taken, linkWe, err}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("stat_rst_br", brCount, 32'd0);
    chk("stat_rst_tk", takenCount, 32'd0);
`endif

    // Three taken beq then a sequential op
    for (int i = 0; i < 3; i++) begin
      fetch(32'h3000);
      br(4'd9, 32'd7, 32'd7, 16'hFFFF, 26'd0, 32'h3000, 1'b1, 1'b0, 32'd0, 1'b0);
    end
    fetch(32'h3000);
    br(4'd13, 32'd0, 32'd0, 16'd0, 26'd0, 32'h3004, 1'b0, 1'b0, 32'd0, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("stat_br", brCount, 32'd3);
    chk("stat_tk", takenCount, 32'd3);
`endif

    // rs == 0 boundary: bgtz not taken, blez taken
    fetch(32'h3004);
    br(4'd12, 32'd0, 32'd0, 16'd2, 26'd0, 32'h3008, 1'b0, 1'b0, 32'd0, 1'b0);
    fetch(32'h3008);
    br(4'd11, 32'd0, 32'd0, 16'd2, 26'd0, 32'h3014, 1'b1, 1'b0, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumer end of the decoder's 4-bit branch-op (BRop) interface in the multi-cycle MIPS core.
- Owns the architectural PC and sequences instruction fetch through a request/ack handshake.
- Resolves each instruction's BRop against register operands, then loads the next PC.
- Issues the $31 link write for the and-link branch forms.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- STAT_W, 32, width of the statistics counters (BRANCH_STATS_EN only).

Ports:
- i_BranchUnit_clk  in  1  clock
- i_BranchUnit_rst  in  1  reset: synchronous, active-high
- o_BranchUnit_fetchReq  out  1  fetch request to instruction memory
- o_BranchUnit_fetchAddr  out  32  fetch address; always equals the PC register
- i_BranchUnit_fetchAck  in  1  instruction memory accepted the fetch
- i_BranchUnit_brValid  in  1  one-cycle pulse: BRop and operands are stable
- i_BranchUnit_BRop  in  4  decoder branch op: 0 jr, 1 j, 2 jal, 3 bal, 4 bgezal, 5 bltz, 6 bgez, 7 bltzal, 8 b, 9 beq, 10 bne, 11 blez, 12 bgtz, 13 sequential, 14-15 illegal
- i_BranchUnit_rsData  in  32  GPR[rs]
- i_BranchUnit_rtData  in  32  GPR[rt]
- i_BranchUnit_imm16  in  16  branch offset field
- i_BranchUnit_target26  in  26  jump target field
- o_BranchUnit_instPc  out  32  address of the instruction in flight
- o_BranchUnit_linkWe  out  1  one-cycle pulse: write link value to $31
- o_BranchUnit_linkAddr  out  32  link value, instPc+4
- o_BranchUnit_taken  out  1  one-cycle pulse: PC redirected
- o_BranchUnit_err  out  1  one-cycle pulse: illegal BRop or misaligned jr target

Behaviour:
- Datapath is fixed at 32 bits. All PC arithmetic is modulo 2^32; wrap-around is silent.
- FSM states:
  - S_FETCH: fetchReq=1. On fetchAck: instPc<=pc, go to S_WAIT. With no ack, fetchReq and fetchAddr hold unchanged.
  - S_WAIT: fetchReq=0. Waits for brValid. On brValid: pc<=next, pulse outputs asserted for exactly the following cycle, go to S_FETCH.
- brValid arriving while in S_FETCH is ignored. fetchAck arriving while in S_WAIT is ignored.
- Only one instruction is in flight at a time; back-to-back brValid pulses are therefore impossible to honour and are ignored.
- Decode/operand sources:
  - seq = instPc+4
  - btgt = instPc+4+(sext(imm16)<<2)
  - jtgt = {seq[31:28], target26, 2'b00}
- Comparisons use the signed 32-bit value of rsData; beq/bne compare rsData with rtData.
- Next-PC selection:
  - 0 jr: {rsData[31:2], 2'b00}. If rsData[1:0]!=0, also pulse err.
  - 1, 2: jtgt.
  - 3, 8: btgt, unconditional.
  - 4, 6: btgt if rs>=0, else seq.
  - 5, 7: btgt if rs<0, else seq.
  - 9: btgt if rs==rt, else seq.
  - 10: btgt if rs!=rt, else seq.
  - 11: btgt if rs<=0, else seq.
  - 12: btgt if rs>0, else seq.
  - 13: seq; never taken.
  - 14, 15: seq plus an err pulse.
- taken pulses whenever next != seq because of a branch or jump decision. A taken branch whose target equals seq still counts as taken.
- Linking:
  - BRop in {2,3,4,7} pulses linkWe with linkAddr=instPc+4.
  - The link is written regardless of the branch condition.
  - linkAddr holds its value until the next link.
- Reset values: pc=RESET_PC, instPc=RESET_PC, state=S_FETCH, fetchReq=1 on the first cycle after reset, linkWe=0, taken=0, err=0, linkAddr=0.
- Reset takes priority over every other input in the same cycle. Reset mid-fetch or mid-wait discards the instruction in flight and emits no pulses.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds output o_BranchUnit_brCount[STAT_W], incremented on every brValid accepted in S_WAIT with BRop<=12.
  - Adds output o_BranchUnit_takenCount[STAT_W], incremented with each taken pulse.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset, then fetchAck held low for 3 cycles -> fetchReq=1 and fetchAddr=32'h3000 stable throughout; ack -> instPc=32'h3000.
- instPc=32'h3000, BRop=9, rs=rt=5, imm16=16'hFFFF -> next fetchAddr=32'h3000, taken=1. BRop=10 with the same inputs -> fetchAddr=32'h3004, taken=0.
- instPc=32'h3010, BRop=4, rs=32'hFFFF_FFFF, imm16=4 -> linkWe=1, linkAddr=32'h3014, taken=0, fetchAddr=32'h3014.
- instPc=32'hF000_0000, BRop=2, target26=26'h0000100 -> fetchAddr=32'hF000_0400, linkAddr=32'hF000_0004.
- BRop=0, rs=32'h0000_4003 -> fetchAddr=32'h4000, err=1. BRop=14 -> fetchAddr=instPc+4, err=1.
- Reset asserted the cycle brValid arrives with BRop=1 -> no taken/linkWe pulse, fetchAddr=32'h3000. With BRANCH_STATS_EN, 3 taken beq plus 1 BRop=13 -> brCount=3, takenCount=3.
